shift_arb: RTL and testbench

SHIFT_ARB -- requirements
Module: shift_arb

---
 rtl/shift_arb_if.sv | 45 ++++
 rtl/shift_arb.sv | 130 +++++++++++++
 tb/tb_shift_arb.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/shift_arb_if.sv
// shift_arb_if: requester, shared-shifter and response signals of shift_arb.
`default_nettype none

interface shift_arb_if;
    logic        req0_valid;
    logic        req0_ready;
    logic [31:0] req0_data;
    logic [4:0]  req0_shamt;
    logic [1:0]  req0_op;
    logic        req1_valid;
    logic        req1_ready;
    logic [31:0] req1_data;
    logic [4:0]  req1_shamt;
    logic [1:0]  req1_op;
    logic [31:0] sh_data;
    logic        sh_direction;
    logic [4:0]  sh_shift;
    logic [31:0] sh_out;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_src;

    // Arbiter side
    modport slave (
        input  req0_valid, req0_data, req0_shamt, req0_op,
        input  req1_valid, req1_data, req1_shamt, req1_op,
        input  sh_out, rsp_ready,
        output req0_ready, req1_ready,
        output sh_data, sh_direction, sh_shift,
        output rsp_valid, rsp_data, rsp_src
    );

    // Requester / shifter / consumer side
    modport master (
        output req0_valid, req0_data, req0_shamt, req0_op,
        output req1_valid, req1_data, req1_shamt, req1_op,
        output sh_out, rsp_ready,
        input  req0_ready, req1_ready,
        input  sh_data, sh_direction, sh_shift,
        input  rsp_valid, rsp_data, rsp_src
    );
endinterface

`default_nettype wire

// File: rtl/shift_arb.sv
// +--------------------------------------------------------------------------+
// | shift_arb: two-requester round-robin arbiter in front of a shared        |
// | combinational shifter. Optional macro SHIFT_ARB_SRA_EN adds sign fill.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module shift_arb (
    input  logic        clk,
    input  logic        rst_n,
    shift_arb_if.slave  bus
);

    localparam logic [1:0] c_OP_SLL  = 2'b00;
    localparam logic [1:0] c_OP_SRL  = 2'b01;
    localparam logic [1:0] c_OP_SRA  = 2'b10;
    localparam logic [1:0] c_OP_PASS = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_ptr;
    logic [31:0] r_data;
    logic [4:0]  r_shamt;
    logic [1:0]  r_op;
    logic        r_src;
    logic        r_rsp_valid;
    logic [31:0] r_rsp_data;
    logic        r_rsp_src;
    logic        w_idle;
    logic        w_grant;
    logic        w_accept;
    logic [31:0] w_result;

    // Pointer only breaks ties; a lone valid requester always wins
    always_comb begin
        w_grant = 1'b0;
        if (bus.req0_valid && bus.req1_valid) begin
            w_grant = r_ptr;
        end else if (bus.req1_valid) begin
            w_grant = 1'b1;
        end
    end

    assign w_idle         = (r_state == S_IDLE);
    assign bus.req0_ready = w_idle & bus.req0_valid & ~w_grant;
    assign bus.req1_ready = w_idle & bus.req1_valid &  w_grant;
    assign w_accept       = bus.req0_ready | bus.req1_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_state_nxt = S_EXEC;
            S_EXEC:  w_state_nxt = S_RESP;
            S_RESP:  if (r_rsp_valid && bus.rsp_ready) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr   <= 1'b0;
            r_data  <= 32'd0;
            r_shamt <= 5'd0;
            r_op    <= 2'b00;
            r_src   <= 1'b0;
        end else if (w_accept) begin
            r_ptr   <= ~w_grant;
            r_data  <= w_grant ? bus.req1_data  : bus.req0_data;
            r_shamt <= w_grant ? bus.req1_shamt : bus.req0_shamt;
            r_op    <= w_grant ? bus.req1_op    : bus.req0_op;
            r_src   <= w_grant;
        end
    end

    // Direction is qualified by state so the reset value of op (SLL) reads as 0
    assign bus.sh_data      = r_data;
    assign bus.sh_shift     = (r_op == c_OP_PASS) ? 5'd0 : r_shamt;
    assign bus.sh_direction = ~w_idle & (r_op == c_OP_SLL);

    always_comb begin
        w_result = bus.sh_out;
        case (r_op)
            c_OP_SLL,
            c_OP_SRL:  w_result = bus.sh_out;
`ifdef SHIFT_ARB_SRA_EN
            c_OP_SRA:  w_result = bus.sh_out |
                                  ({32{r_data[31]}} & ~(32'hFFFF_FFFF >> r_shamt));
`else
            c_OP_SRA:  w_result = bus.sh_out;
`endif
            c_OP_PASS: w_result = r_data;
            default:   w_result = bus.sh_out;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= 32'd0;
            r_rsp_src   <= 1'b0;
        end else if (r_state == S_EXEC) begin
            r_rsp_valid <= 1'b1;
            r_rsp_data  <= w_result;
            r_rsp_src   <= r_src;
        end else if ((r_state == S_RESP) && r_rsp_valid && bus.rsp_ready) begin
            r_rsp_valid <= 1'b0;
        end
    end

    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_data  = r_rsp_data;
    assign bus.rsp_src   = r_rsp_src;

endmodule

`default_nettype wire

// File: tb/tb_shift_arb.sv
// tb_shift_arb: directed vectors for shift_arb with a behavioural shared shifter.
`default_nettype none

module tb_shift_arb;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;

    shift_arb_if bus ();

    shift_arb u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    // External shared shifter: plain logical shift in the requested direction
    assign bus.sh_out = bus.sh_direction ? (bus.sh_data << bus.sh_shift)
                                         : (bus.sh_data >> bus.sh_shift);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit port, input bit v, input logic [31:0] d,
                         input logic [4:0] s, input logic [1:0] op);
        if (port) begin
            bus.req1_valid = v; bus.req1_data = d; bus.req1_shamt = s; bus.req1_op = op;
        end else begin
            bus.req0_valid = v; bus.req0_data = d; bus.req0_shamt = s; bus.req0_op = op;
        end
    endtask

    // One uncontended operation from IDLE through the response handshake
    task automatic do_op(input string tag, input bit port, input logic [31:0] d,
                         input logic [4:0] s, input logic [1:0] op,
                         input logic [31:0] exp);
        drive(port, 1'b1, d, s, op);
        #1;
        chk({tag, ".ready"}, port ? bus.req1_ready : bus.req0_ready, 32'd1);
        tick();
        drive(port, 1'b0, 32'hDEAD_BEEF, 5'd13, 2'b01);
        #1;
        chk({tag, ".exec_valid"}, bus.rsp_valid, 32'd0);
        chk({tag, ".exec_shift"}, bus.sh_shift, (op == 2'b11) ? 32'd0 : 32'(s));
        chk({tag, ".exec_dir"}, bus.sh_direction, (op == 2'b00) ? 32'd1 : 32'd0);
        tick();
        chk({tag, ".rsp_valid"}, bus.rsp_valid, 32'd1);
        chk({tag, ".rsp_data"}, bus.rsp_data, exp);
        chk({tag, ".rsp_src"}, bus.rsp_src, 32'(port));
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
        chk({tag, ".done"}, bus.rsp_valid, 32'd0);
    endtask

    initial begin
        logic [31:0] exp_sra;
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        bus.rsp_ready = 1'b0;
        drive(1'b0, 1'b0, 32'd0, 5'd0, 2'b00);
        drive(1'b1, 1'b0, 32'd0, 5'd0, 2'b00);

        #23;
        chk("rst.rsp_valid", bus.rsp_valid, 32'd0);
        chk("rst.rsp_data", bus.rsp_data, 32'd0);
        chk("rst.rsp_src", bus.rsp_src, 32'd0);
        chk("rst.sh_data", bus.sh_data, 32'd0);
        chk("rst.sh_dir", bus.sh_direction, 32'd0);
        chk("rst.sh_shift", bus.sh_shift, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // rsp_ready with nothing pending must not change anything
        bus.rsp_ready = 1'b1;
        tick();
        tick();
        bus.rsp_ready = 1'b0;
        chk("idle_ready.valid", bus.rsp_valid, 32'd0);

        do_op("sll1", 1'b0, 32'h0000_0001, 5'd4, 2'b00, 32'h0000_0010);
`ifdef SHIFT_ARB_SRA_EN
        exp_sra = 32'hF800_000F;
`else
        exp_sra = 32'h0800_000F;
`endif
        do_op("sra_neg", 1'b1, 32'h8000_00F0, 5'd4, 2'b10, exp_sra);
        do_op("sra_pos", 1'b0, 32'h7000_0000, 5'd4, 2'b10, 32'h0700_0000);
        do_op("srl31", 1'b1, 32'hFFFF_FFFF, 5'd31, 2'b01, 32'h0000_0001);
        do_op("pass7", 1'b0, 32'h1234_5678, 5'd7, 2'b11, 32'h1234_5678);
        do_op("sll0", 1'b1, 32'h8000_0001, 5'd0, 2'b00, 32'h8000_0001);
        do_op("srl0", 1'b0, 32'h8000_0001, 5'd0, 2'b01, 32'h8000_0001);
        do_op("sra0", 1'b1, 32'h8000_0001, 5'd0, 2'b10, 32'h8000_0001);
        do_op("pass0", 1'b0, 32'h8000_0001, 5'd0, 2'b11, 32'h8000_0001);

        // Backpressure: hold the response for 5 cycles with req1 waiting
        drive(1'b0, 1'b1, 32'h0000_0003, 5'd2, 2'b00);
        tick();
        drive(1'b0, 1'b0, 32'd0, 5'd0, 2'b00);
        tick();
        drive(1'b1, 1'b1, 32'h0000_0055, 5'd9, 2'b11);
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp.valid", bus.rsp_valid, 32'd1);
            chk("bp.data", bus.rsp_data, 32'h0000_000C);
            chk("bp.src", bus.rsp_src, 32'd0);
            chk("bp.ready0", bus.req0_ready, 32'd0);
            chk("bp.ready1", bus.req1_ready, 32'd0);
            tick();
        end
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
        chk("bp.release_valid", bus.rsp_valid, 32'd0);
        chk("bp.release_ready1", bus.req1_ready, 32'd1);
        tick();
        drive(1'b1, 1'b0, 32'd0, 5'd0, 2'b00);
        tick();
        chk("bp.next_data", bus.rsp_data, 32'h0000_0055);
        chk("bp.next_src", bus.rsp_src, 32'd1);
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;

        // Reset while in EXEC drops the operation
        drive(1'b0, 1'b1, 32'h0000_00FF, 5'd1, 2'b00);
        tick();
        drive(1'b0, 1'b0, 32'd0, 5'd0, 2'b00);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rstx.valid", bus.rsp_valid, 32'd0);
        chk("rstx.sh_data", bus.sh_data, 32'd0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("rstx.no_rsp", bus.rsp_valid, 32'd0);
        end

        // Contention straight after reset: req0, req1, req0
        drive(1'b0, 1'b1, 32'h0000_0001, 5'd1, 2'b00);
        drive(1'b1, 1'b1, 32'h0000_0100, 5'd4, 2'b01);
        for (int i = 0; i < 3; i++) begin
            logic exp_src;
            exp_src = (i == 1);
            #1;
            chk("rr.ready0", bus.req0_ready, 32'(!exp_src));
            chk("rr.ready1", bus.req1_ready, 32'(exp_src));
            tick();
            chk("rr.exec_ready", 32'(bus.req0_ready | bus.req1_ready), 32'd0);
            tick();
            chk("rr.src", bus.rsp_src, 32'(exp_src));
            chk("rr.data", bus.rsp_data, exp_src ? 32'h0000_0010 : 32'h0000_0002);
            bus.rsp_ready = 1'b1;
            tick();
            bus.rsp_ready = 1'b0;
        end
        drive(1'b0, 1'b0, 32'd0, 5'd0, 2'b00);
        drive(1'b1, 1'b0, 32'd0, 5'd0, 2'b00);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
